// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RISC-V controller: FSM states, ALU
// operation classes, ALU control codes and the opcodes the decoder recognises.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_ERROR    = 4'd15
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b011;
   localparam logic [2:0] ALUC_XOR = 3'b100;
   localparam logic [2:0] ALUC_SLT = 3'b101;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Immediate format select; a pure function of the opcode.
   function automatic logic [1:0] imm_src(input logic [6:0] op);
      logic [1:0] sel;
      case (op)
         OP_LOAD, OP_ITYPE: sel = 2'b00;
         OP_STORE:          sel = 2'b01;
         OP_BRANCH:         sel = 2'b10;
         OP_JAL:            sel = 2'b11;
         default:           sel = 2'b00;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle
// controller; the datapath side is the master, the controller the slave.
interface multicycle_ctrl_if;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       mem_ready;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;
   logic       error;

   modport master (
      output op, funct3, funct7b5, Zero, mem_ready,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state, error
   );

   modport slave (
      input  op, funct3, funct7b5, Zero, mem_ready,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state, error
   );

endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the ALU operation class and instruction fields onto the
// 3-bit ALU control code.
module mc_aludec
   import riscv_mc_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   // Decode the ALU operation; only register-register ops honour funct7b5.
   always_comb begin
      alu_control = ALUC_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALUC_ADD;
         ALUOP_SUB: alu_control = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (funct7b5 && op5) ? ALUC_SUB : ALUC_ADD;
               3'b010:  alu_control = ALUC_SLT;
               3'b100:  alu_control = ALUC_XOR;
               3'b110:  alu_control = ALUC_OR;
               3'b111:  alu_control = ALUC_AND;
               default: alu_control = ALUC_ADD;
            endcase
         end
         default: alu_control = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: state machine, per-state datapath
// controls, branch resolution and immediate select.
module multicycle_ctrl
   import riscv_mc_pkg::*;
#(
   parameter int ILLEGAL_HALT = 1
)(
   input logic               clk,
   input logic               reset,
   multicycle_ctrl_if.slave  bus
);

   localparam state_t ILLEGAL_NEXT = (ILLEGAL_HALT != 0) ? S_ERROR : S_FETCH;

   state_t     state_r;
   state_t     state_next_s;
   logic       pc_update_s;
   logic       branch_s;
   logic       adr_src_s;
   logic       mem_write_s;
   logic       ir_write_s;
   logic       reg_write_s;
   logic       error_s;
   logic [1:0] result_src_s;
   logic [1:0] alu_src_a_s;
   logic [1:0] alu_src_b_s;
   logic [1:0] alu_op_s;
   logic [2:0] alu_control_s;

   // State register; reset forces FETCH at once, even mid-stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state selection and per-state control outputs.
   always_comb begin
      state_next_s = state_r;
      pc_update_s  = 1'b0;
      branch_s     = 1'b0;
      adr_src_s    = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      error_s      = 1'b0;
      result_src_s = 2'b00;
      alu_src_a_s  = 2'b00;
      alu_src_b_s  = 2'b00;
      alu_op_s     = ALUOP_ADD;
      case (state_r)
         S_FETCH: begin
            // IR and PC load only on the cycle the memory delivers the word.
            ir_write_s   = bus.mem_ready;
            pc_update_s  = bus.mem_ready;
            alu_src_b_s  = 2'b10;
            result_src_s = 2'b10;
            state_next_s = bus.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a_s = 2'b01;
            alu_src_b_s = 2'b01;
            case (bus.op)
               OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
               OP_RTYPE:          state_next_s = S_EXECR;
               OP_ITYPE:          state_next_s = S_EXECI;
               OP_JAL:            state_next_s = S_JAL;
               OP_BRANCH:         state_next_s = S_BRANCH;
               default:           state_next_s = ILLEGAL_NEXT;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_s  = 2'b10;
            alu_src_b_s  = 2'b01;
            state_next_s = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src_s    = 1'b1;
            state_next_s = bus.mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src_s = 2'b01;
            reg_write_s  = 1'b1;
            state_next_s = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src_s    = 1'b1;
            mem_write_s  = 1'b1;
            state_next_s = bus.mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a_s  = 2'b10;
            alu_op_s     = ALUOP_FUNCT;
            state_next_s = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a_s  = 2'b10;
            alu_src_b_s  = 2'b01;
            alu_op_s     = ALUOP_FUNCT;
            state_next_s = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s  = 1'b1;
            state_next_s = S_FETCH;
         end
         S_JAL: begin
            alu_src_a_s  = 2'b01;
            alu_src_b_s  = 2'b10;
            pc_update_s  = 1'b1;
            state_next_s = S_ALUWB;
         end
         S_BRANCH: begin
            alu_src_a_s  = 2'b10;
            alu_op_s     = ALUOP_SUB;
            branch_s     = 1'b1;
            state_next_s = S_FETCH;
         end
         S_ERROR: begin
            error_s      = 1'b1;
            state_next_s = S_ERROR;
         end
         default: begin
            // Unused encodings are treated like an illegal instruction.
            state_next_s = ILLEGAL_NEXT;
         end
      endcase
   end

   mc_aludec u_aludec (
      .alu_op      (alu_op_s),
      .funct3      (bus.funct3),
      .funct7b5    (bus.funct7b5),
      .op5         (bus.op[5]),
      .alu_control (alu_control_s)
   );

   // funct3[0] inverts the sense of Zero, turning beq into bne.
   assign bus.PCWrite    = pc_update_s | (branch_s & (bus.Zero ^ bus.funct3[0]));
   assign bus.AdrSrc     = adr_src_s;
   assign bus.MemWrite   = mem_write_s;
   assign bus.IRWrite    = ir_write_s;
   assign bus.RegWrite   = reg_write_s;
   assign bus.ResultSrc  = result_src_s;
   assign bus.ALUSrcA    = alu_src_a_s;
   assign bus.ALUSrcB    = alu_src_b_s;
   assign bus.ImmSrc     = imm_src(bus.op);
   assign bus.ALUControl = alu_control_s;
   assign bus.state      = state_r;
   assign bus.error      = error_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a table of whole instructions with
// hand-computed state sequences, plus directed stall, reset and illegal cases.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_if bus();

   multicycle_ctrl #(.ILLEGAL_HALT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [6:0]      op;
      logic [2:0]      f3;
      logic            f7;
      logic            z;
      int              len;
      logic [5:0][3:0] st;
      logic [5:0]      pcw;
      logic [2:0]      alu_x;
      logic [1:0]      imm;
   } vec_t;

   localparam int NV = 15;
   vec_t vec [NV];

   function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic z, input int len,
                               input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                               input logic [3:0] s3, input logic [3:0] s4,
                               input logic [5:0] pcw, input logic [2:0] alu_x,
                               input logic [1:0] imm);
      vec_t r;
      r.op = op; r.f3 = f3; r.f7 = f7; r.z = z; r.len = len;
      r.st = '0;
      r.st[0] = s0; r.st[1] = s1; r.st[2] = s2; r.st[3] = s3; r.st[4] = s4;
      r.pcw = pcw; r.alu_x = alu_x; r.imm = imm;
      return r;
   endfunction

   // Expected {AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,error}, mem_ready=1.
   function automatic logic [10:0] exp_ctrl(input logic [3:0] s);
      case (s)
         4'd0:    return {1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0};
         4'd1:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0};
         4'd2:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0};
         4'd3:    return {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
         4'd4:    return {1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0};
         4'd5:    return {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
         4'd6:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
         4'd7:    return {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0};
         4'd8:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0};
         4'd9:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0};
         4'd10:   return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
         4'd15:   return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
         default: return 11'h7FF;
      endcase
   endfunction

   function automatic logic [10:0] act_ctrl();
      return {bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
              bus.ALUSrcA, bus.ALUSrcB, bus.error};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      vec[0]  = mk(7'b0000011, 3'b010, 1'b0, 1'b0, 5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 6'b000001, 3'b000, 2'b00);
      vec[1]  = mk(7'b0100011, 3'b010, 1'b0, 1'b0, 4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 6'b000001, 3'b000, 2'b01);
      vec[2]  = mk(7'b0110011, 3'b000, 1'b0, 1'b0, 4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 6'b000001, 3'b000, 2'b00);
      vec[3]  = mk(7'b0110011, 3'b000, 1'b1, 1'b0, 4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 6'b000001, 3'b001, 2'b00);
      vec[4]  = mk(7'b0110011, 3'b100, 1'b0, 1'b0, 4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 6'b000001, 3'b100, 2'b00);
      vec[5]  = mk(7'b0110011, 3'b010, 1'b0, 1'b0, 4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 6'b000001, 3'b101, 2'b00);
      vec[6]  = mk(7'b0110011, 3'b110, 1'b0, 1'b0, 4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 6'b000001, 3'b011, 2'b00);
      vec[7]  = mk(7'b0110011, 3'b111, 1'b0, 1'b0, 4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 6'b000001, 3'b010, 2'b00);
      vec[8]  = mk(7'b0110011, 3'b001, 1'b0, 1'b0, 4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 6'b000001, 3'b000, 2'b00);
      vec[9]  = mk(7'b0010011, 3'b000, 1'b1, 1'b0, 4, 4'd0, 4'd1, 4'd8, 4'd7, 4'd0, 6'b000001, 3'b000, 2'b00);
      vec[10] = mk(7'b1101111, 3'b000, 1'b0, 1'b0, 4, 4'd0, 4'd1, 4'd9, 4'd7, 4'd0, 6'b000101, 3'b000, 2'b11);
      vec[11] = mk(7'b1100011, 3'b000, 1'b0, 1'b1, 3, 4'd0, 4'd1, 4'd10, 4'd0, 4'd0, 6'b000101, 3'b001, 2'b10);
      vec[12] = mk(7'b1100011, 3'b001, 1'b0, 1'b1, 3, 4'd0, 4'd1, 4'd10, 4'd0, 4'd0, 6'b000001, 3'b001, 2'b10);
      vec[13] = mk(7'b1100011, 3'b001, 1'b0, 1'b0, 3, 4'd0, 4'd1, 4'd10, 4'd0, 4'd0, 6'b000101, 3'b001, 2'b10);
      vec[14] = mk(7'b1100011, 3'b000, 1'b0, 1'b0, 3, 4'd0, 4'd1, 4'd10, 4'd0, 4'd0, 6'b000001, 3'b001, 2'b10);

      // Reset with memory not ready: FETCH, nothing written.
      reset = 1'b1;
      bus.op = 7'b0000000; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
      bus.Zero = 1'b0; bus.mem_ready = 1'b0;
      #12;
      chk("reset_state", 16'(bus.state), 16'd0);
      chk("reset_error", 16'(bus.error), 16'd0);
      chk("reset_irwrite", 16'(bus.IRWrite), 16'd0);
      chk("reset_pcwrite", 16'(bus.PCWrite), 16'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      next_cycle();
      next_cycle();
      chk("fetch_stall_state", 16'(bus.state), 16'd0);
      chk("fetch_stall_irwrite", 16'(bus.IRWrite), 16'd0);
      bus.mem_ready = 1'b1;
      #1;
      chk("fetch_ready_irwrite", 16'(bus.IRWrite), 16'd1);
      chk("fetch_ready_pcwrite", 16'(bus.PCWrite), 16'd1);

      // Table-driven whole instructions, mem_ready held high.
      for (int v = 0; v < NV; v++) begin
         bus.op = vec[v].op; bus.funct3 = vec[v].f3; bus.funct7b5 = vec[v].f7;
         bus.Zero = vec[v].z; bus.mem_ready = 1'b1;
         #1;
         for (int i = 0; i < vec[v].len; i++) begin
            chk($sformatf("v%0d c%0d state", v, i), 16'(bus.state), 16'(vec[v].st[i]));
            chk($sformatf("v%0d c%0d ctrl", v, i), 16'(act_ctrl()), 16'(exp_ctrl(vec[v].st[i])));
            chk($sformatf("v%0d c%0d pcwrite", v, i), 16'(bus.PCWrite), 16'(vec[v].pcw[i]));
            chk($sformatf("v%0d c%0d alucontrol", v, i), 16'(bus.ALUControl),
                16'((i == 2) ? vec[v].alu_x : 3'b000));
            chk($sformatf("v%0d c%0d immsrc", v, i), 16'(bus.ImmSrc), 16'(vec[v].imm));
            next_cycle();
         end
         chk($sformatf("v%0d end_state", v), 16'(bus.state), 16'd0);
      end

      // Store with three stall cycles in MEMWRITE.
      bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
      next_cycle(); next_cycle(); next_cycle();
      chk("sw_stall_enter", 16'(bus.state), 16'd5);
      bus.mem_ready = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) bus.mem_ready = 1'b1;
         #1;
         if (bus.state == 4'd5 && bus.MemWrite && bus.AdrSrc) cnt++;
         next_cycle();
      end
      chk("sw_stall_memwrite_cycles", 16'(cnt), 16'd4);
      chk("sw_stall_exit_state", 16'(bus.state), 16'd0);

      // Load stalled in MEMREAD, then reset mid-stall.
      bus.op = 7'b0000011; bus.mem_ready = 1'b1;
      next_cycle(); next_cycle(); next_cycle();
      chk("lw_memread", 16'(bus.state), 16'd3);
      bus.mem_ready = 1'b0;
      next_cycle();
      chk("lw_memread_stall", 16'(bus.state), 16'd3);
      reset = 1'b1;
      #1;
      chk("rst_memread_state", 16'(bus.state), 16'd0);
      chk("rst_memread_regwrite", 16'(bus.RegWrite), 16'd0);
      chk("rst_memread_memwrite", 16'(bus.MemWrite), 16'd0);
      chk("rst_memread_adrsrc", 16'(bus.AdrSrc), 16'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;

      // Illegal opcode parks in ERROR until reset.
      bus.op = 7'b1111111; bus.mem_ready = 1'b1;
      next_cycle();
      chk("illegal_decode", 16'(bus.state), 16'd1);
      next_cycle();
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.state != 4'd15 || !bus.error || bus.PCWrite || bus.IRWrite ||
             bus.RegWrite || bus.MemWrite || bus.AdrSrc) cnt++;
         next_cycle();
      end
      chk("error_hold_bad_cycles", 16'(cnt), 16'd0);
      chk("error_state", 16'(bus.state), 16'd15);
      reset = 1'b1;
      #1;
      chk("error_reset_state", 16'(bus.state), 16'd0);
      chk("error_reset_error", 16'(bus.error), 16'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ILLEGAL_HALT, default 1: 1 = an unknown opcode parks the FSM in ERROR; 0 = it returns to FETCH.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 op  input  7  instruction opcode, taken from the instruction register.
REQ-005 funct3  input  3  instruction bits 14:12.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  unified memory completes the current access this cycle.
REQ-009 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables and selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-011 ALUControl  output  3  ALU operation code.
REQ-012 state  output  4  current FSM state encoding, for debug and bench observation.
REQ-013 error  output  1  high while in ERROR.

Function
REQ-014 FSM states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, ERROR=15.
REQ-015 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1; stays in FETCH while mem_ready=0; IRWrite and PCWrite are asserted only in the cycle mem_ready=1.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (PC target precompute); next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1101111 -> JAL
- 1100011 -> BRANCH
- other -> ERROR or FETCH per ILLEGAL_HALT
REQ-017 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; -> MEMREAD if op=0000011, else -> MEMWRITE.
REQ-018 MEMREAD: ResultSrc=00, AdrSrc=1; hold until mem_ready=1, then -> MEMWB.
REQ-019 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-020 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held until mem_ready=1; -> FETCH on ready.
REQ-021 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both -> ALUWB.
REQ-022 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-023 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; -> ALUWB.
REQ-024 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> FETCH.
REQ-025 PCWrite = PCUpdate or (Branch and (Zero xor funct3[0])), so funct3=000 gives beq and funct3=001 gives bne.
REQ-026 ERROR: all enables 0, error=1; left only by reset.
REQ-027 Every signal not listed for a state is 0 in that state; no X on any output at any time.
REQ-028 ImmSrc is combinational from op:
- 0000011, 0010011 -> 00
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- other -> 00
REQ-029 ALU decode:
- ALUOp=00 -> 000 (add); ALUOp=01 -> 001 (sub)
- ALUOp=10 by funct3: 000 -> sub (001) if funct7b5 and op[5], else add (000); 010 -> 101 (slt); 100 -> 100 (xor); 110 -> 011 (or); 111 -> 010 (and); other -> 000.
REQ-030 Instruction latency with mem_ready held at 1:
- lw: 5 cycles
- sw: 4 cycles
- R-type, I-type, jal: 4 cycles
- branch: 3 cycles
Each stall cycle (mem_ready=0) adds one cycle.

Reset
REQ-031 Reset asserted, at any time including mid-instruction or mid-stall: state goes to FETCH immediately, error=0, and all enables go to 0 except those FETCH drives.
REQ-032 After reset deasserts, the first rising edge with mem_ready=1 writes IR and PC.

Structure
REQ-033 A shared package riscv_mc_pkg holds the state enum, ALUOp encodings, ALUControl constants and opcode constants.
REQ-034 A single sub-module, mc_aludec, implements REQ-029; the FSM and main decode stay in multicycle_ctrl.

Verification
REQ-035 Reset, then lw (op=0000011), mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01.
REQ-036 sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 and AdrSrc=1 held for 4 cycles; then state 0.
REQ-037 R-type funct3=000, funct7b5=1 -> ALUControl=001 in EXECR; funct3=100 -> ALUControl=100.
REQ-038 Branch funct3=000 with Zero=1 -> PCWrite=1 in BRANCH; funct3=001 with Zero=1 -> PCWrite=0.
REQ-039 op=1111111 with ILLEGAL_HALT=1 -> state 15, error=1, held 20 cycles; reset asserted -> state 0.
REQ-040 Reset asserted in MEMREAD -> state=0 the same cycle with RegWrite=0 and MemWrite=0.
